alu_req_arbiter: RTL and testbench

Shares one ALU datapath (arithmetic, logic, compare and shift units behind a common operand bus) between NUM_REQ requesters. It arbitrates pending requests and issues the winner's operands with a single unit-enable pulse. It waits out the units' one-cycle registered output, then returns the result and flag to the winner tagged with its index. It sits between the client blocks and the ALU top, replacing direct decoder drive.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_rr_pick.sv | 39 +++
 rtl/alu_req_arbiter.sv | 148 ++++++++++++++
 tb/tb_alu_req_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU unit-select encodings, compare codes and arbiter FSM state type
package alu_pkg;

    localparam logic [1:0] UNIT_ARITH = 2'b00;
    localparam logic [1:0] UNIT_LOGIC = 2'b01;
    localparam logic [1:0] UNIT_CMP   = 2'b10;
    localparam logic [1:0] UNIT_SHIFT = 2'b11;

    // Compare-unit function codes; a true compare returns its own code as data.
    localparam logic [1:0] CMP_NOP = 2'b00;
    localparam logic [1:0] CMP_EQ  = 2'b01;
    localparam logic [1:0] CMP_GT  = 2'b10;
    localparam logic [1:0] CMP_LT  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10
    } arb_state_e;

    // One-hot unit enable vector ordered {shift, cmp, logic, arith}.
    function automatic logic [3:0] unit_enables(input logic [1:0] unit);
        logic [3:0] en;
        en = '0;
        en[unit] = 1'b1;
        return en;
    endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// rtl/alu_rr_pick.sv - combinational requester picker; ALU_ARB_FIXED_PRI_EN selects fixed priority
module alu_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
`ifndef ALU_ARB_FIXED_PRI_EN
    input  logic [ID_W-1:0]    ptr,
`endif
    output logic [ID_W-1:0]    win,
    output logic               any_req
);

    assign any_req = |req;

`ifdef ALU_ARB_FIXED_PRI_EN
    // Descending scan so the lowest set index is the last writer.
    always_comb begin
        win = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) win = ID_W'(i);
        end
    end
`else
    int idx;

    // Scan offsets from ptr downwards so the smallest offset wins.
    always_comb begin
        win = '0;
        idx = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[idx]) win = ID_W'(idx);
        end
    end
`endif

endmodule

// File: rtl/alu_req_arbiter.sv
// rtl/alu_req_arbiter.sv - shares one ALU datapath among NUM_REQ requesters; ALU_ARB_FIXED_PRI_EN selects fixed priority
module alu_req_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      Clk,
    input  logic                      RST,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [4*NUM_REQ-1:0]      req_op,
    input  logic [DATA_W*NUM_REQ-1:0] req_a,
    input  logic [DATA_W*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [1:0]                alu_fun,
    output logic                      arith_en,
    output logic                      logic_en,
    output logic                      cmp_en,
    output logic                      shift_en,
    input  logic [DATA_W-1:0]         alu_out,
    input  logic                      alu_flag,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_flag
);

    arb_state_e state, state_d;

    logic [ID_W-1:0]    win, win_id, win_id_d;
    logic               any_req;
    logic [3:0]         en, en_d;
    logic [NUM_REQ-1:0] gnt_d;
    logic [DATA_W-1:0]  alu_a_d, alu_b_d, rsp_data_d;
    logic [1:0]         alu_fun_d;
    logic               rsp_valid_d, rsp_flag_d;
    logic [ID_W-1:0]    rsp_id_d;

    logic [3:0]         op_arr [NUM_REQ];
    logic [DATA_W-1:0]  a_arr  [NUM_REQ];
    logic [DATA_W-1:0]  b_arr  [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign op_arr[i] = req_op[4*i +: 4];
        assign a_arr[i]  = req_a[DATA_W*i +: DATA_W];
        assign b_arr[i]  = req_b[DATA_W*i +: DATA_W];
    end

    assign {shift_en, cmp_en, logic_en, arith_en} = en;

`ifdef ALU_ARB_FIXED_PRI_EN
    alu_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
        .req     (req),
        .win     (win),
        .any_req (any_req)
    );
`else
    logic [ID_W-1:0] ptr, ptr_d;

    alu_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
        .req     (req),
        .ptr     (ptr),
        .win     (win),
        .any_req (any_req)
    );
`endif

    always_comb begin
        state_d     = state;
        gnt_d       = '0;
        en_d        = '0;
        alu_a_d     = alu_a;
        alu_b_d     = alu_b;
        alu_fun_d   = alu_fun;
        win_id_d    = win_id;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id;
        rsp_data_d  = rsp_data;
        rsp_flag_d  = rsp_flag;
`ifndef ALU_ARB_FIXED_PRI_EN
        ptr_d       = ptr;
`endif
        case (state)
            IDLE: begin
                if (any_req) begin
                    alu_fun_d  = op_arr[win][1:0];
                    alu_a_d    = a_arr[win];
                    alu_b_d    = b_arr[win];
                    en_d       = unit_enables(op_arr[win][3:2]);
                    gnt_d[win] = 1'b1;
                    win_id_d   = win;
`ifndef ALU_ARB_FIXED_PRI_EN
                    ptr_d      = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
`endif
                    state_d    = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                // Units register their result during ISSUE, so alu_out is valid now.
                rsp_valid_d = 1'b1;
                rsp_id_d    = win_id;
                rsp_data_d  = alu_out;
                rsp_flag_d  = alu_flag;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            gnt       <= '0;
            en        <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_fun   <= '0;
            win_id    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_flag  <= 1'b0;
`ifndef ALU_ARB_FIXED_PRI_EN
            ptr       <= '0;
`endif
        end else begin
            state     <= state_d;
            gnt       <= gnt_d;
            en        <= en_d;
            alu_a     <= alu_a_d;
            alu_b     <= alu_b_d;
            alu_fun   <= alu_fun_d;
            win_id    <= win_id_d;
            rsp_valid <= rsp_valid_d;
            rsp_id    <= rsp_id_d;
            rsp_data  <= rsp_data_d;
            rsp_flag  <= rsp_flag_d;
`ifndef ALU_ARB_FIXED_PRI_EN
            ptr       <= ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb/tb_alu_req_arbiter.sv - self-checking bench for alu_req_arbiter; honours ALU_ARB_FIXED_PRI_EN
module tb_alu_req_arbiter;
    import alu_pkg::*;

    localparam int DATA_W  = 16;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                      Clk = 1'b0;
    logic                      RST;
    logic [NUM_REQ-1:0]        req;
    logic [4*NUM_REQ-1:0]      req_op;
    logic [DATA_W*NUM_REQ-1:0] req_a, req_b;
    logic [NUM_REQ-1:0]        gnt;
    logic [DATA_W-1:0]         alu_a, alu_b, alu_out, rsp_data;
    logic [1:0]                alu_fun;
    logic                      arith_en, logic_en, cmp_en, shift_en, alu_flag;
    logic                      rsp_valid, rsp_flag;
    logic [ID_W-1:0]           rsp_id;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    alu_req_arbiter #(.DATA_W(DATA_W), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .Clk(Clk), .RST(RST), .req(req), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
        .arith_en(arith_en), .logic_en(logic_en), .cmp_en(cmp_en), .shift_en(shift_en),
        .alu_out(alu_out), .alu_flag(alu_flag), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_flag(rsp_flag)
    );

    // Datapath behaviour returned as {flag, data}.
    function automatic logic [DATA_W:0] alu_calc(input logic [3:0] op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        logic f;
        r = '0;
        f = 1'b0;
        case (op[3:2])
            2'b00: case (op[1:0]) 2'b00: r = a + b; 2'b01: r = a - b; 2'b10: r = a + 1'b1; default: r = a - 1'b1; endcase
            2'b01: case (op[1:0]) 2'b00: r = a & b; 2'b01: r = a | b; 2'b10: r = a ^ b; default: r = ~(a & b); endcase
            2'b10: begin
                case (op[1:0]) 2'b00: f = 1'b0; 2'b01: f = (a == b); 2'b10: f = (a > b); default: f = (a < b); endcase
                r = f ? DATA_W'(op[1:0]) : '0;
            end
            default: case (op[1:0])
                2'b00: r = a << b[3:0]; 2'b01: r = a >> b[3:0];
                2'b10: r = DATA_W'($signed(a) >>> b[3:0]); default: r = a << 1;
            endcase
        endcase
        if (op[3:2] != 2'b10) f = (r == '0);
        return {f, r};
    endfunction

    // Units register their output one cycle after the enable; disabled units give 0.
    logic [DATA_W:0] env_res;
    assign env_res = alu_calc({shift_en | cmp_en, shift_en | logic_en, alu_fun}, alu_a, alu_b);

    always @(posedge Clk or negedge RST) begin
        if (!RST) begin
            alu_out  <= '0;
            alu_flag <= 1'b0;
        end else if (arith_en | logic_en | cmp_en | shift_en) begin
            alu_out  <= env_res[DATA_W-1:0];
            alu_flag <= env_res[DATA_W];
        end else begin
            alu_out  <= '0;
            alu_flag <= 1'b0;
        end
    end

    // Reference model: one arbitration opportunity every 3 cycles, response 3 cycles after the decision.
    int cyc, next_free, rsp_at, m_ptr, pend_id, e_id;
    logic [DATA_W:0]    pend_rsp, e_rsp;
    logic [NUM_REQ-1:0] e_gnt;
    logic [3:0]         e_en;
    logic [DATA_W-1:0]  e_a, e_b;
    logic [1:0]         e_fun;
    logic               e_rv;
    bit                 auto_drop;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        e_gnt = '0; e_en = '0; e_a = '0; e_b = '0; e_fun = '0;
        e_rv = 1'b0; e_id = 0; e_rsp = '0;
        m_ptr = 0; next_free = 0; rsp_at = -100;
    endtask

    task automatic model_edge();
        int w;
        logic [3:0] op;
        w = -1;
        e_gnt = '0;
        e_en = '0;
        e_rv = (rsp_at == cyc + 1);
        if (e_rv) begin
            e_id = pend_id;
            e_rsp = pend_rsp;
        end
        if (cyc >= next_free && req != '0) begin
`ifdef ALU_ARB_FIXED_PRI_EN
            for (int k = 0; k < NUM_REQ; k++) if (w < 0 && req[k]) w = k;
`else
            for (int k = 0; k < NUM_REQ; k++) if (w < 0 && req[(m_ptr + k) % NUM_REQ]) w = (m_ptr + k) % NUM_REQ;
            m_ptr = (w + 1) % NUM_REQ;
`endif
            op = req_op[4*w +: 4];
            e_gnt[w] = 1'b1;
            e_en[op[3:2]] = 1'b1;
            e_fun = op[1:0];
            e_a = req_a[DATA_W*w +: DATA_W];
            e_b = req_b[DATA_W*w +: DATA_W];
            pend_id = w;
            pend_rsp = alu_calc(op, e_a, e_b);
            rsp_at = cyc + 3;
            next_free = cyc + 3;
        end
    endtask

    task automatic compare_all();
        check("gnt", gnt, e_gnt);
        check("unit_en", {shift_en, cmp_en, logic_en, arith_en}, e_en);
        check("en_onehot", ($countones({shift_en, cmp_en, logic_en, arith_en}) <= 1), 1'b1);
        check("alu_a", alu_a, e_a);
        check("alu_b", alu_b, e_b);
        check("alu_fun", alu_fun, e_fun);
        check("rsp_valid", rsp_valid, e_rv);
        if (e_rv) begin
            check("rsp_id", rsp_id, e_id);
            check("rsp_data", rsp_data, e_rsp[DATA_W-1:0]);
            check("rsp_flag", rsp_flag, e_rsp[DATA_W]);
        end
    endtask

    task automatic step();
        if (RST) model_edge();
        else model_reset();
        @(posedge Clk);
        cyc++;
        @(negedge Clk);
        compare_all();
        if (auto_drop) req = req & ~e_gnt;
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        req_op[4*i +: 4] = op;
        req_a[DATA_W*i +: DATA_W] = a;
        req_b[DATA_W*i +: DATA_W] = b;
        req[i] = 1'b1;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        step();
        RST = 1'b1;
    endtask

    initial begin
        req = '0; req_op = '0; req_a = '0; req_b = '0;
        RST = 1'b0; cyc = 0; auto_drop = 1'b1;
        pend_id = 0; pend_rsp = '0;
        model_reset();
        step();
        step();
        RST = 1'b1;

        // Single compare: 9 > 3
        set_req(2, 4'b1010, 16'd9, 16'd3);
        step();
        check("cmp_gnt", gnt, 4'b0100);
        check("cmp_en", cmp_en, 1'b1);
        check("cmp_fun", alu_fun, 2'b10);
        step();
        step();
        check("cmp_rsp_valid", rsp_valid, 1'b1);
        check("cmp_rsp_id", rsp_id, 2);
        check("cmp_rsp_data", rsp_data, 16'h0002);
        check("cmp_rsp_flag", rsp_flag, 1'b1);

        // Reset during WAIT with requester 1 still pending
        set_req(0, 4'b0001, 16'h00f0, 16'h000f);
        set_req(1, 4'b0000, 16'd100, 16'd23);
        step();
        step();
        RST = 1'b0;
        #1;
        check("rst_async_gnt", gnt, 4'b0000);
        check("rst_async_en", {shift_en, cmp_en, logic_en, arith_en}, 4'b0000);
        check("rst_async_a", alu_a, 16'h0000);
        step();
        check("rst_no_rsp", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp_data, 16'h0000);
        RST = 1'b1;
        step();
        check("rst_regrant", gnt, 4'b0010);
        repeat (2) step();

        // Wrap and skip: grant 2 leaves ptr at 3, then 0 and 2 pending
        do_reset();
        set_req(2, 4'b0111, 16'h1234, 16'h0003);
        repeat (3) step();
        set_req(0, 4'b1101, 16'h8000, 16'h0004);
        set_req(2, 4'b0010, 16'h00ff, 16'h0f0f);
        step();
        check("wrap_first", gnt, 4'b0001);
        repeat (2) step();
        step();
        check("wrap_second", gnt, 4'b0100);
        repeat (2) step();

        // Withdrawn request: req[3] high only across the ISSUE edge
        set_req(0, 4'b0100, 16'haaaa, 16'h5555);
        step();
        set_req(3, 4'b1000, 16'd1, 16'd1);
        step();
        req[3] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            check("withdraw_gnt3", gnt[3], 1'b0);
            check("withdraw_rsp3", (rsp_valid && rsp_id == 2'd3), 1'b0);
        end

`ifdef ALU_ARB_FIXED_PRI_EN
        // Fixed priority: requester 1 always beats 3
        do_reset();
        auto_drop = 1'b0;
        set_req(1, 4'b0001, 16'h0011, 16'h0100);
        set_req(3, 4'b1111, 16'h0022, 16'h0200);
        for (int k = 0; k < 5; k++) begin
            step();
            check("fixpri_gnt", gnt, 4'b0010);
            repeat (2) step();
        end
`else
        // Round-robin with all requests held
        do_reset();
        auto_drop = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 4'(i * 5), 16'(i * 7 + 3), 16'(i + 1));
        for (int k = 0; k < 5; k++) begin
            step();
            check("rr_order", gnt, 4'b0001 << (k % NUM_REQ));
            repeat (2) step();
        end
`endif

        // Randomized traffic with grant-driven release and occasional withdrawal
        req = '0;
        do_reset();
        auto_drop = 1'b1;
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0)
                    set_req(i, 4'($urandom), 16'($urandom), 16'($urandom));
                else if (req[i] && $urandom_range(0, 15) == 0)
                    req[i] = 1'b0;
            end
            if (n == 300) begin
                RST = 1'b0;
                step();
                RST = 1'b1;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
